// File: rtl/rv32i_pkg.sv
// Shared constants for the register file / issue scoreboard slice.
package rv32i_pkg;

  // Controller state encoding.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // The clear sweep counts 1..NREG-1, so it needs clog2(NREG) bits.
  // It is never narrower than one bit.
  function automatic int sweep_w(input int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, writeback and issue signals of the register file with scoreboard.
interface regfile_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   Rd_Addr;
  logic [NRD*XLEN-1:0] Rd_Data;
  logic [NRD-1:0]      Rd_Busy;
  logic                Wr_En;
  logic [AW-1:0]       Wr_Addr;
  logic [XLEN-1:0]     Wr_Data;
  logic                Iss_En;
  logic [AW-1:0]       Iss_Addr;
  logic                Iss_Stall;
  logic                Ready;
  logic [NREG-1:0]     Busy_Vec;

  // Pipeline side: presents addresses, writebacks and issues.
  modport master (
    output Rd_Addr, Wr_En, Wr_Addr, Wr_Data, Iss_En, Iss_Addr,
    input  Rd_Data, Rd_Busy, Iss_Stall, Ready, Busy_Vec
  );

  // Register file side.
  modport slave (
    input  Rd_Addr, Wr_En, Wr_Addr, Wr_Data, Iss_En, Iss_Addr,
    output Rd_Data, Rd_Busy, Iss_Stall, Ready, Busy_Vec
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write tracker: one busy bit per register, set by an accepted
// issue and cleared by writeback. Produces per-port busy flags and the
// issue stall. Register 0 is never tracked.
module rf_scoreboard #(
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              run,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic              iss_stall,
  output logic [NREG-1:0]   busy_vec
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [AW-1:0]   ra;
  logic            iss_ok;

  // A register being written back this cycle is no longer a hazard.
  always_comb begin
    rd_busy = '0;
    ra      = '0;
    for (int k = 0; k < NRD; k++) begin
      ra         = rd_addr[k*AW +: AW];
      rd_busy[k] = busy_q[ra] & ~(wr_en & (wr_addr == ra));
    end
  end

  // A second issue to a still-pending destination waits (WAW); the
  // requester simply retries, nothing is queued here.
  always_comb begin
    iss_stall = iss_en & busy_q[iss_addr] & ~(wr_en & (wr_addr == iss_addr));
    iss_ok    = run & iss_en & ~iss_stall & (iss_addr != '0);
  end

  // Clear on writeback first, then set on issue, so a same-cycle pair
  // leaves the register pending.
  always_comb begin
    busy_d = busy_q;
    if (run && wr_en) busy_d[wr_addr] = 1'b0;
    if (iss_ok) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy vector state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write bypass, a zeroing sweep after reset and an
// issue scoreboard. Register 0 is hardwired to zero.
module regfile_scoreboard
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  regfile_scoreboard_if.slave  bus
);

  localparam int AW = $clog2(NREG);
  localparam int SW = sweep_w(NREG);

  logic [0:0]          state_q, state_d;
  logic [SW-1:0]       sweep_q, sweep_d;
  logic [XLEN-1:0]     mem_q [NREG];
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [XLEN-1:0]     mem_wdata;
  logic                run;
  logic [AW-1:0]       ra;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                sb_stall;
  logic [NREG-1:0]     busy_vec;

  assign run = (state_q == ST_RUN);

  // Sweep one register per cycle after reset, then run normally.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      if (sweep_q == SW'(NREG - 1)) state_d = ST_RUN;
      else                          sweep_d = sweep_q + SW'(1);
    end
  end

  // Controller state; the sweep always restarts from register 1.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_INIT;
      sweep_q <= SW'(1);
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Single array write port: the sweep owns it during INIT, writeback
  // owns it in RUN. Writes to register 0 are dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = AW'(sweep_q);
    end else if (bus.Wr_En && bus.Wr_Addr != '0) begin
      mem_we    = 1'b1;
      mem_waddr = bus.Wr_Addr;
      mem_wdata = bus.Wr_Data;
    end
  end

  // Array storage; contents are only ever zeroed by the sweep.
  always_ff @(posedge Clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Combinational reads with same-cycle writeback forwarding; nothing is
  // visible until the sweep has finished.
  always_comb begin
    rd_data = '0;
    ra      = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = bus.Rd_Addr[k*AW +: AW];
      if (run && ra != '0) begin
        if (bus.Wr_En && bus.Wr_Addr == ra) rd_data[k*XLEN +: XLEN] = bus.Wr_Data;
        else                                rd_data[k*XLEN +: XLEN] = mem_q[ra];
      end
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .AW   (AW)
  ) u_sb (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .run       (run),
    .wr_en     (bus.Wr_En),
    .wr_addr   (bus.Wr_Addr),
    .iss_en    (bus.Iss_En),
    .iss_addr  (bus.Iss_Addr),
    .rd_addr   (bus.Rd_Addr),
    .rd_busy   (rd_busy),
    .iss_stall (sb_stall),
    .busy_vec  (busy_vec)
  );

  assign bus.Rd_Data   = rd_data;
  assign bus.Rd_Busy   = rd_busy;
  assign bus.Iss_Stall = ~run | sb_stall;
  assign bus.Ready     = run;
  assign bus.Busy_Vec  = busy_vec;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard (XLEN=32, NREG=32, NRD=2).
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  localparam int K_RD    = 0;
  localparam int K_RBUSY = 1;
  localparam int K_STALL = 2;
  localparam int K_READY = 3;
  localparam int K_BBIT  = 4;
  localparam int K_BVEC  = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int kind, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = v;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int kind, input int idx);
    case (kind)
      K_RD:    return bus.Rd_Data[idx*XLEN +: XLEN];
      K_RBUSY: return {31'b0, bus.Rd_Busy[idx]};
      K_STALL: return {31'b0, bus.Iss_Stall};
      K_READY: return {31'b0, bus.Ready};
      K_BBIT:  return {31'b0, bus.Busy_Vec[idx]};
      default: return bus.Busy_Vec;
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check_val(e.tag, observe(e.kind, e.idx), e.exp);
    end
  endtask

  // Inputs are driven at posedge+1; outputs are compared at the negedge.
  task automatic step();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Wr_En    = 1'b0;
    bus.Wr_Addr  = '0;
    bus.Wr_Data  = '0;
    bus.Iss_En   = 1'b0;
    bus.Iss_Addr = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.Rd_Addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic drive_wr(input int a, input logic [31:0] d);
    bus.Wr_En   = 1'b1;
    bus.Wr_Addr = AW'(a);
    bus.Wr_Data = d;
  endtask

  task automatic drive_iss(input int a);
    bus.Iss_En   = 1'b1;
    bus.Iss_Addr = AW'(a);
  endtask

  // Called right after reset release (posedge+1); counts rising edges
  // until Ready is seen, bounded.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.Ready && n < 40);
    idle();
    check_val(tag, n, 32'd31);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.Rd_Addr = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    set_rd(0, 9);
    set_rd(1, 0);
    expect_out("rst_ready", K_READY, 0, 32'd0);
    expect_out("rst_stall", K_STALL, 0, 32'd1);
    expect_out("rst_busy",  K_BVEC,  0, 32'd0);
    expect_out("rst_rd0",   K_RD,    0, 32'd0);
    step();

    // Release; writes and issues during the sweep must be ignored
    rst_n = 1'b1;
    drive_wr(9, 32'hFFFF_0009);
    drive_iss(9);
    expect_out("init_rd_bypass", K_RD,    0, 32'd0);
    expect_out("init_stall",     K_STALL, 0, 32'd1);
    @(negedge clk);
    drain();
    wait_ready("ready_latency");

    // Everything reads zero, nothing pending
    expect_out("run_busy_zero", K_BVEC,  0, 32'd0);
    expect_out("run_stall_idle", K_STALL, 0, 32'd0);
    for (int r = 0; r < NREG; r += 2) begin
      set_rd(0, r);
      set_rd(1, r + 1);
      expect_out($sformatf("zero_r%0d", r),     K_RD, 0, 32'd0);
      expect_out($sformatf("zero_r%0d", r + 1), K_RD, 1, 32'd0);
      step();
    end

    // Same-cycle bypass, then the stored value
    set_rd(0, 5);
    set_rd(1, 6);
    drive_wr(5, 32'hDEAD_BEEF);
    expect_out("byp_same_cycle", K_RD, 0, 32'hDEAD_BEEF);
    expect_out("byp_other_port", K_RD, 1, 32'd0);
    step();
    idle();
    set_rd(1, 5);
    expect_out("wr_landed_p0", K_RD, 0, 32'hDEAD_BEEF);
    expect_out("wr_landed_p1", K_RD, 1, 32'hDEAD_BEEF);
    step();

    // WAW stall, then writeback + issue in one cycle
    set_rd(1, 7);
    drive_iss(7);
    expect_out("iss7_first_stall", K_STALL, 0, 32'd0);
    expect_out("iss7_pre_busy",    K_BBIT,  7, 32'd0);
    step();
    expect_out("iss7_again_stall", K_STALL, 0, 32'd1);
    expect_out("busy7_set",        K_BBIT,  7, 32'd1);
    expect_out("rdbusy7",          K_RBUSY, 1, 32'd1);
    step();
    drive_wr(7, 32'h0000_0777);
    drive_iss(7);
    expect_out("wb_iss7_stall", K_STALL, 0, 32'd0);
    expect_out("wb7_rdbusy",    K_RBUSY, 1, 32'd0);
    expect_out("wb7_bypass",    K_RD,    1, 32'h0000_0777);
    step();
    idle();
    expect_out("busy7_kept",   K_BBIT,  7, 32'd1);
    expect_out("rd7_data",     K_RD,    1, 32'h0000_0777);
    expect_out("rdbusy7_kept", K_RBUSY, 1, 32'd1);
    step();
    drive_wr(7, 32'h0000_0778);
    step();
    idle();
    expect_out("busy7_clear", K_BVEC, 0, 32'd0);
    expect_out("rd7_new",     K_RD,   1, 32'h0000_0778);
    step();

    // Register 0: no write, no busy, no stall
    set_rd(0, 0);
    drive_wr(0, 32'h1234_5678);
    drive_iss(0);
    expect_out("r0_bypass",    K_RD,    0, 32'd0);
    expect_out("r0_iss_stall", K_STALL, 0, 32'd0);
    step();
    expect_out("r0_iss_again", K_STALL, 0, 32'd0);
    expect_out("r0_busyvec",   K_BVEC,  0, 32'd0);
    expect_out("r0_read",      K_RD,    0, 32'd0);
    step();
    idle();

    // Issue reg 3, then write it back
    set_rd(1, 3);
    drive_iss(3);
    step();
    idle();
    drive_wr(3, 32'hA5A5_A5A5);
    expect_out("wb3_rdbusy",   K_RBUSY, 1, 32'd0);
    expect_out("wb3_bypass",   K_RD,    1, 32'hA5A5_A5A5);
    expect_out("wb3_busy_pre", K_BBIT,  3, 32'd1);
    step();
    idle();
    expect_out("rd3_after",     K_RD,    1, 32'hA5A5_A5A5);
    expect_out("rdbusy3_after", K_RBUSY, 1, 32'd0);
    expect_out("busy3_clear",   K_BBIT,  3, 32'd0);
    step();

    // Per-port busy flags; writeback to a register that is not pending
    drive_iss(20);
    step();
    idle();
    set_rd(0, 20);
    set_rd(1, 21);
    drive_wr(21, 32'h2121_0021);
    expect_out("rdbusy20", K_RBUSY, 0, 32'd1);
    expect_out("rdbusy21", K_RBUSY, 1, 32'd0);
    step();
    idle();
    expect_out("busyvec_20", K_BVEC, 0, 32'h0010_0000);
    expect_out("rd21",       K_RD,   1, 32'h2121_0021);
    expect_out("rd20_old",   K_RD,   0, 32'd0);
    step();

    // Reset in RUN with several registers pending
    drive_iss(4);
    step();
    drive_iss(9);
    step();
    idle();
    expect_out("busy_before_rst", K_BVEC, 0, 32'h0010_0210);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    set_rd(0, 5);
    #1;
    expect_out("runrst_busy",  K_BVEC,  0, 32'd0);
    expect_out("runrst_ready", K_READY, 0, 32'd0);
    expect_out("runrst_stall", K_STALL, 0, 32'd1);
    expect_out("runrst_rd",    K_RD,    0, 32'd0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("ready_after_run_reset");
    set_rd(0, 5);
    set_rd(1, 21);
    expect_out("resweep_r5",   K_RD,   0, 32'd0);
    expect_out("resweep_r21",  K_RD,   1, 32'd0);
    expect_out("resweep_busy", K_BVEC, 0, 32'd0);
    step();

    // Reset at sweep index 10
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    #2;
    expect_out("midsweep_ready_pre", K_READY, 0, 32'd0);
    drain();
    rst_n = 1'b0;
    #1;
    expect_out("midsweep_ready", K_READY, 0, 32'd0);
    expect_out("midsweep_stall", K_STALL, 0, 32'd1);
    expect_out("midsweep_busy",  K_BVEC,  0, 32'd0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("ready_after_sweep_reset");
    expect_out("final_ready", K_READY, 0, 32'd1);
    expect_out("final_rd5",   K_RD,    0, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two, 2..64.
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1..4.
REQ-004 SHALL have derived localparam AW = clog2(NREG), address width.
REQ-005 SHALL have port Clock  in  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port Reset_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port Rd_Addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-008 SHALL have port Rd_Data  out  NRD*XLEN  packed read data, combinational.
REQ-009 SHALL have port Rd_Busy  out  NRD  per-port flag: the addressed register has a pending write.
REQ-010 SHALL have port Wr_En  in  1  writeback strobe.
REQ-011 SHALL have port Wr_Addr  in  AW  writeback destination.
REQ-012 SHALL have port Wr_Data  in  XLEN  writeback data.
REQ-013 SHALL have port Iss_En  in  1  issue request that marks Iss_Addr pending.
REQ-014 SHALL have port Iss_Addr  in  AW  issue destination.
REQ-015 SHALL have port Iss_Stall  out  1  issue refused this cycle.
REQ-016 SHALL have port Ready  out  1  initialisation sweep complete.
REQ-017 SHALL have port Busy_Vec  out  NREG  raw pending bits; bit 0 is always 0.

Function
REQ-018 SHALL implement a two-state FSM, INIT and RUN; INIT is entered on reset.
REQ-019 In INIT, SHALL write zero to one register per cycle, using a sweep counter running 1..NREG-1.
REQ-020 After the clear of register NREG-1, SHALL move to RUN; Ready SHALL be 1 from the next cycle, i.e. NREG-1 cycles after reset release.
REQ-021 In INIT, SHALL ignore Wr_En and Iss_En, hold Iss_Stall = 1 and drive Rd_Data to zero.
REQ-022 Register 0 SHALL read as zero, ignore writes, never become busy, and never cause a stall.
REQ-023 Reads SHALL be combinational from the array.
REQ-024 Write bypass: if Wr_En is set and Wr_Addr equals Rd_Addr[k] and the address is nonzero, Rd_Data[k] SHALL equal Wr_Data in that same cycle.
REQ-025 A write SHALL land in the array at the rising edge when Wr_En is set in RUN.
REQ-026 Writeback SHALL clear busy[Wr_Addr] at the edge.
REQ-027 Rd_Busy[k] SHALL equal busy[Rd_Addr[k]] AND NOT (Wr_En AND Wr_Addr equals Rd_Addr[k]).
REQ-028 Iss_Stall SHALL equal Iss_En AND busy[Iss_Addr] AND NOT (Wr_En AND Wr_Addr equals Iss_Addr), so a WAW issue waits.
REQ-029 An issue accepted with Iss_Addr nonzero (Iss_En set, no stall, in RUN) SHALL set busy[Iss_Addr] at the edge.
REQ-030 Writeback and accepted issue to the same address in one cycle SHALL leave busy set (issue wins) and still write the data.
REQ-031 Writeback to a non-busy register SHALL be legal: data written, busy unchanged at 0.
REQ-032 Iss_Stall SHALL be purely combinational, with no internal queuing; the requester retries.

Reset
REQ-033 Reset_n low SHALL asynchronously force state INIT, sweep counter 1, all busy bits 0, Ready 0 and Iss_Stall 1.
REQ-034 Array contents SHALL NOT be async-reset; they are zeroed only by the INIT sweep.
REQ-035 Reset asserted mid-sweep or mid-RUN SHALL restart a full sweep after release.

Structure
REQ-036 FSM state encoding and the sweep-counter width rule SHALL live in shared package rv32i_pkg.
REQ-037 SHALL have one sub-module, rf_scoreboard, holding the busy vector, the Rd_Busy/Iss_Stall logic and the set/clear arbitration; the array, the bypass and the FSM stay in the top level.

Verification
REQ-038 Release reset with NREG=32 -> Ready rises exactly 31 cycles later; every Rd_Data reads 0 and Busy_Vec = 0.
REQ-039 In RUN, write 0xDEADBEEF to reg 5 with Rd_Addr[0]=5 in the same cycle -> Rd_Data[0]=0xDEADBEEF combinationally and on the next cycle.
REQ-040 Issue reg 7, then issue reg 7 again -> Busy_Vec[7]=1 and the second issue gets Iss_Stall=1; writeback reg 7 plus issue reg 7 in one cycle -> no stall, Busy_Vec[7] stays 1.
REQ-041 Write 0x12345678 to reg 0 and issue reg 0 -> reads 0, Busy_Vec[0]=0, Iss_Stall=0.
REQ-042 Assert Reset_n low at sweep index 10 and again in RUN with busy bits set -> Busy_Vec clears immediately, Ready=0, and the full 31-cycle sweep repeats.
REQ-043 Issue reg 3 then write back 0xA5A5A5A5 -> Rd_Busy[1] for addr 3 is 0 in the writeback cycle and reads 0xA5A5A5A5 thereafter.
